seven_seg_mux_driver: RTL and testbench

Parametrised, registered multiplexed driver for common-anode seven-segment displays in the ALSU front panel. It latches a binary result and shows it in hexadecimal or decimal across `DIGITS` time-multiplexed digits. Decimal conversion uses a sequential double-dabble engine. The block adds leading-zero blanking, decimal overflow indication, an "Err" message, and per-digit PWM brightness. It sits between the ALSU result/invalid outputs and the board's `an`/`seg` pins.

---
 rtl/seven_seg_mux_driver_pkg.sv | 48 ++++
 rtl/seven_seg_mux_driver_bin2bcd_seq.sv | 80 ++++++++
 rtl/seven_seg_mux_driver.sv | 160 ++++++++++++++++
 tb/tb_seven_seg_mux_driver.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/seven_seg_mux_driver_pkg.sv
// Glyph constants and the hex-to-glyph font shared by the seven-segment display blocks.
// Segment order is {a,b,c,d,e,f,g}; all patterns are active-low for common-anode parts.
package seg_defs;

    localparam logic [6:0] SEG_0     = 7'b0000001;
    localparam logic [6:0] SEG_1     = 7'b1001111;
    localparam logic [6:0] SEG_2     = 7'b0010010;
    localparam logic [6:0] SEG_3     = 7'b0000110;
    localparam logic [6:0] SEG_4     = 7'b1001100;
    localparam logic [6:0] SEG_5     = 7'b0100100;
    localparam logic [6:0] SEG_6     = 7'b0100000;
    localparam logic [6:0] SEG_7     = 7'b0001111;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0000100;
    localparam logic [6:0] SEG_A     = 7'b0001000;
    localparam logic [6:0] SEG_B     = 7'b1100000;
    localparam logic [6:0] SEG_C     = 7'b0110001;
    localparam logic [6:0] SEG_D     = 7'b1000010;
    localparam logic [6:0] SEG_E     = 7'b0110000;
    localparam logic [6:0] SEG_F     = 7'b0111000;
    localparam logic [6:0] SEG_DASH  = 7'b1111110;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_r     = 7'b1111010;

    function automatic logic [6:0] hex_glyph(input logic [3:0] code);
        logic [6:0] g;
        case (code)
            4'h0:    g = SEG_0;
            4'h1:    g = SEG_1;
            4'h2:    g = SEG_2;
            4'h3:    g = SEG_3;
            4'h4:    g = SEG_4;
            4'h5:    g = SEG_5;
            4'h6:    g = SEG_6;
            4'h7:    g = SEG_7;
            4'h8:    g = SEG_8;
            4'h9:    g = SEG_9;
            4'hA:    g = SEG_A;
            4'hB:    g = SEG_B;
            4'hC:    g = SEG_C;
            4'hD:    g = SEG_D;
            4'hE:    g = SEG_E;
            default: g = SEG_F;
        endcase
        return g;
    endfunction

endpackage

// File: rtl/seven_seg_mux_driver_bin2bcd_seq.sv
// Sequential double-dabble converter: one add-3/shift iteration per clock, VAL_W iterations,
// with the result held on bcd/ovf once done pulses until the next start.
module bin2bcd_seq
    import seg_defs::*;
#(
    parameter int VAL_W  = 14,
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [VAL_W-1:0]      bin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  ovf
);

    localparam int          BCD_W     = 4 * DIGITS;
    localparam int          SH_W      = BCD_W + VAL_W;
    localparam int          CNT_W     = $clog2(VAL_W + 1);
    localparam logic [63:0] OVF_LIMIT = 64'(10) ** DIGITS;

    logic [SH_W-1:0]  sh_q, sh_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             ovf_q, ovf_d;

    function automatic logic [SH_W-1:0] dabble(input logic [SH_W-1:0] s);
        logic [SH_W-1:0] t;
        t = s;
        for (int d = 0; d < DIGITS; d++) begin
            if (t[VAL_W + 4*d +: 4] >= 4'd5) begin
                t[VAL_W + 4*d +: 4] = t[VAL_W + 4*d +: 4] + 4'd3;
            end
        end
        return {t[SH_W-2:0], 1'b0};
    endfunction

    // The start cycle already performs the first iteration, so cnt counts completed shifts.
    always_comb begin
        sh_d   = sh_q;
        cnt_d  = cnt_q;
        busy_d = busy_q;
        ovf_d  = ovf_q;
        if (start && !busy_q) begin
            sh_d   = dabble({{BCD_W{1'b0}}, bin});
            cnt_d  = CNT_W'(1);
            busy_d = 1'b1;
            ovf_d  = (64'(bin) >= OVF_LIMIT);
        end else if (busy_q) begin
            if (cnt_q == CNT_W'(VAL_W)) begin
                busy_d = 1'b0;
            end else begin
                sh_d  = dabble(sh_q);
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh_q   <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            sh_q   <= sh_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
            ovf_q  <= ovf_d;
        end
    end

    assign busy = busy_q;
    assign done = busy_q && (cnt_q == CNT_W'(VAL_W));
    assign bcd  = sh_q[SH_W-1 -: BCD_W];
    assign ovf  = ovf_q;

endmodule

// File: rtl/seven_seg_mux_driver.sv
// Multiplexed common-anode seven-segment driver: latches a value, shows it in hex or decimal
// across DIGITS scanned digits with leading-zero blanking, overflow dashes, "Err" and PWM dimming.
module seven_seg_mux_driver
    import seg_defs::*;
#(
    parameter int DIGITS      = 4,
    parameter int VAL_W       = 14,
    parameter int REFRESH_CYC = 100_000,
    parameter int BRIGHT_W    = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [VAL_W-1:0]    value,
    input  logic                load,
    input  logic                mode,
    input  logic                blank_lz,
    input  logic                invalid,
    input  logic [BRIGHT_W-1:0] bright,
    output logic                busy,
    output logic [DIGITS-1:0]   an,
    output logic [6:0]          seg
);

    localparam int SEL_W  = $clog2(DIGITS);
    localparam int SLOT_W = $clog2(REFRESH_CYC);
    localparam int STEP   = REFRESH_CYC >> BRIGHT_W;
    localparam int STEP_W = (STEP > 1) ? $clog2(STEP) : 1;

    logic                     ld_q, ld_d;
    logic [VAL_W-1:0]         val_q, val_d;
    logic                     mode_q, mode_d;
    logic                     accept;

    logic [DIGITS-1:0][3:0]   shadow_q, shadow_d;
    logic                     ovf_q, ovf_d;

    logic                     eng_busy, eng_done, eng_ovf;
    logic [4*DIGITS-1:0]      eng_bcd;

    logic [SLOT_W-1:0]        slot_cnt_q, slot_cnt_d;
    logic [STEP_W-1:0]        step_q, step_d;
    logic [BRIGHT_W-1:0]      phase_q, phase_d;
    logic [SEL_W-1:0]         sel_q, sel_d;
    logic                     slot_wrap, step_wrap;

    logic [SEL_W-1:0]         msd;
    logic [6:0]               seg_d, seg_q;
    logic [DIGITS-1:0]        an_d, an_q;

    // A decimal request waiting for the engine to start counts as busy, so it cannot be overwritten.
    assign accept = load && !eng_busy && !(ld_q && mode_q);

    always_comb begin
        ld_d   = accept;
        val_d  = accept ? value : val_q;
        mode_d = accept ? mode  : mode_q;
    end

    bin2bcd_seq #(
        .VAL_W  (VAL_W),
        .DIGITS (DIGITS)
    ) u_bin2bcd (
        .clk   (clk),
        .rst   (rst),
        .start (ld_q && mode_q),
        .bin   (val_q),
        .busy  (eng_busy),
        .done  (eng_done),
        .bcd   (eng_bcd),
        .ovf   (eng_ovf)
    );

    always_comb begin
        shadow_d = shadow_q;
        ovf_d    = ovf_q;
        if (ld_q && !mode_q) begin
            shadow_d = (4*DIGITS)'(val_q);
            ovf_d    = 1'b0;
        end else if (eng_done) begin
            shadow_d = eng_bcd;
            ovf_d    = eng_ovf;
        end
    end

    // step/phase track slot_cnt / STEP incrementally instead of dividing.
    always_comb begin
        slot_wrap  = (slot_cnt_q == SLOT_W'(REFRESH_CYC - 1));
        step_wrap  = (step_q == STEP_W'(STEP - 1));
        slot_cnt_d = slot_wrap ? '0 : slot_cnt_q + SLOT_W'(1);
        step_d     = step_wrap ? '0 : step_q + STEP_W'(1);
        phase_d    = phase_q;
        sel_d      = sel_q;
        if (slot_wrap) begin
            phase_d = '0;
            sel_d   = (sel_q == SEL_W'(DIGITS - 1)) ? '0 : sel_q + SEL_W'(1);
        end else if (step_wrap) begin
            phase_d = phase_q + BRIGHT_W'(1);
        end
    end

    always_comb begin
        msd = '0;
        for (int i = 1; i < DIGITS; i++) begin
            if (shadow_q[i] != 4'd0) begin
                msd = SEL_W'(i);
            end
        end

        if (invalid) begin
            if (sel_q == SEL_W'(DIGITS - 1)) begin
                seg_d = SEG_E;
            end else if (sel_q == SEL_W'(DIGITS - 2) || sel_q == SEL_W'(DIGITS - 3)) begin
                seg_d = SEG_r;
            end else begin
                seg_d = SEG_BLANK;
            end
        end else if (ovf_q) begin
            seg_d = SEG_DASH;
        end else if (blank_lz && (sel_q > msd)) begin
            seg_d = SEG_BLANK;
        end else begin
            seg_d = hex_glyph(shadow_q[sel_q]);
        end

        an_d = (phase_q <= bright) ? ~(DIGITS'(1) << sel_q) : '1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ld_q       <= 1'b0;
            val_q      <= '0;
            mode_q     <= 1'b0;
            shadow_q   <= '0;
            ovf_q      <= 1'b0;
            slot_cnt_q <= '0;
            step_q     <= '0;
            phase_q    <= '0;
            sel_q      <= '0;
            an_q       <= '1;
            seg_q      <= SEG_BLANK;
        end else begin
            ld_q       <= ld_d;
            val_q      <= val_d;
            mode_q     <= mode_d;
            shadow_q   <= shadow_d;
            ovf_q      <= ovf_d;
            slot_cnt_q <= slot_cnt_d;
            step_q     <= step_d;
            phase_q    <= phase_d;
            sel_q      <= sel_d;
            an_q       <= an_d;
            seg_q      <= seg_d;
        end
    end

    assign busy = eng_busy;
    assign an   = an_q;
    assign seg  = seg_q;

endmodule

// File: tb/tb_seven_seg_mux_driver.sv
// Directed bench for seven_seg_mux_driver with a short refresh period so whole scans are quick.
module tb_seven_seg_mux_driver;

    localparam int DIGITS      = 4;
    localparam int VAL_W       = 14;
    localparam int REFRESH_CYC = 8;
    localparam int BRIGHT_W    = 2;

    localparam logic [6:0] G0    = 7'b0000001;
    localparam logic [6:0] G1    = 7'b1001111;
    localparam logic [6:0] G2    = 7'b0010010;
    localparam logic [6:0] G3    = 7'b0000110;
    localparam logic [6:0] G4    = 7'b1001100;
    localparam logic [6:0] G5    = 7'b0100100;
    localparam logic [6:0] G7    = 7'b0001111;
    localparam logic [6:0] GA    = 7'b0001000;
    localparam logic [6:0] GE    = 7'b0110000;
    localparam logic [6:0] GR    = 7'b1111010;
    localparam logic [6:0] GDASH = 7'b1111110;
    localparam logic [6:0] GOFF  = 7'b1111111;

    logic                clk      = 1'b0;
    logic                rst      = 1'b1;
    logic [VAL_W-1:0]    value    = '0;
    logic                load     = 1'b0;
    logic                mode     = 1'b0;
    logic                blank_lz = 1'b0;
    logic                invalid  = 1'b0;
    logic [BRIGHT_W-1:0] bright   = '1;
    logic                busy;
    logic [DIGITS-1:0]   an;
    logic [6:0]          seg;

    int total = 0;
    int bad   = 0;
    int k;
    int lit;
    logic [3:0] exp_an;
    logic [6:0] exp_seg;
    logic [6:0] hold [4];

    always #5 clk = ~clk;

    seven_seg_mux_driver #(
        .DIGITS      (DIGITS),
        .VAL_W       (VAL_W),
        .REFRESH_CYC (REFRESH_CYC),
        .BRIGHT_W    (BRIGHT_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .value    (value),
        .load     (load),
        .mode     (mode),
        .blank_lz (blank_lz),
        .invalid  (invalid),
        .bright   (bright),
        .busy     (busy),
        .an       (an),
        .seg      (seg)
    );

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int an_idx(input logic [3:0] a);
        int r;
        logic [3:0] one;
        r = -1;
        for (int i = 0; i < 4; i++) begin
            one = 4'b0001 << i;
            if (a === ~one) r = i;
        end
        return r;
    endfunction

    function automatic logic [6:0] err_glyph(input int idx);
        if (idx == 3) return GE;
        if (idx == 2 || idx == 1) return GR;
        if (idx == 0) return GOFF;
        return 7'bxxxxxxx;
    endfunction

    task automatic do_load(input logic [VAL_W-1:0] v, input logic m);
        value = v;
        mode  = m;
        load  = 1'b1;
        tick();
        load  = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (busy !== 1'b0 && n < 40) begin
            tick();
            n++;
        end
        check(tag, 16'(busy), 16'h0);
    endtask

    // Watches a full scan (after settling) and records the glyph seen on each lit digit.
    task automatic check_digits(input string tag, input logic [6:0] e0, input logic [6:0] e1,
                                input logic [6:0] e2, input logic [6:0] e3);
        logic [6:0] exp [4];
        logic [6:0] got [4];
        int idx;
        exp = '{e0, e1, e2, e3};
        for (int i = 0; i < 4; i++) got[i] = 7'bxxxxxxx;
        tick();
        tick();
        for (int c = 0; c < REFRESH_CYC * DIGITS; c++) begin
            tick();
            idx = an_idx(an);
            if (idx >= 0) got[idx] = seg;
        end
        for (int i = 0; i < 4; i++) begin
            check($sformatf("%s_d%0d", tag, i), 16'(got[i]), 16'(exp[i]));
        end
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("rst_an", 16'(an), 16'h000F);
        check("rst_seg", 16'(seg), 16'h007F);
        check("rst_busy", 16'(busy), 16'h0000);
        rst = 1'b0;

        for (int c = 0; c <= 32; c++) begin
            tick();
            exp_an = ~(4'b0001 << ((c / 8) % 4));
            if (c % 8 == 0 || c % 8 == 7) check("scan_sel", 16'(an), 16'(exp_an));
            if (c == 0) check("first_slot_seg", 16'(seg), 16'(G0));
        end

        do_load(14'h2A5, 1'b0);
        for (int c = 0; c < 4; c++) begin
            tick();
            check("hex_busy", 16'(busy), 16'h0000);
        end
        check_digits("hex", G5, GA, G2, G0);

        hold = '{G5, GA, G2, G0};
        do_load(14'd1234, 1'b1);
        check("dec_busy_t0", 16'(busy), 16'h0000);
        for (int c = 1; c <= 14; c++) begin
            tick();
            check("dec_busy_hi", 16'(busy), 16'h0001);
            k = an_idx(an);
            exp_seg = (k < 0) ? 7'bxxxxxxx : hold[k];
            check("dec_hold", 16'(seg), 16'(exp_seg));
            if (c == 5) begin
                value = 14'd9999;
                load  = 1'b1;
            end
            if (c == 6) load = 1'b0;
        end
        tick();
        check("dec_busy_fall", 16'(busy), 16'h0000);
        check_digits("dec1234", G4, G3, G2, G1);

        do_load(14'd10000, 1'b1);
        tick();
        wait_idle("ovf_idle");
        check_digits("ovf", GDASH, GDASH, GDASH, GDASH);
        do_load(14'd0, 1'b0);
        check_digits("ovf_clear", G0, G0, G0, G0);

        blank_lz = 1'b1;
        do_load(14'd7, 1'b1);
        tick();
        wait_idle("lz_idle");
        check_digits("lz", G7, GOFF, GOFF, GOFF);

        invalid = 1'b1;
        tick();
        k = an_idx(an);
        check("err_latency", 16'(seg), 16'(err_glyph(k)));
        check_digits("err", GOFF, GR, GR, GE);
        invalid = 1'b0;
        blank_lz = 1'b0;
        check_digits("lz_off", G7, G0, G0, G0);

        bright = 2'd0;
        tick();
        lit = 0;
        for (int c = 0; c < 8; c++) begin
            tick();
            if (an !== 4'hF) lit++;
        end
        check("pwm_b0", 16'(lit), 16'd2);
        bright = 2'd1;
        tick();
        lit = 0;
        for (int c = 0; c < 8; c++) begin
            tick();
            if (an !== 4'hF) lit++;
        end
        check("pwm_b1", 16'(lit), 16'd4);
        bright = 2'd3;
        tick();
        lit = 0;
        for (int c = 0; c < 8; c++) begin
            tick();
            if (an !== 4'hF) lit++;
        end
        check("pwm_b3", 16'(lit), 16'd8);

        do_load(14'd1234, 1'b1);
        repeat (5) tick();
        check("rc_busy_before", 16'(busy), 16'h0001);
        #2;
        rst = 1'b1;
        #1;
        check("rc_busy", 16'(busy), 16'h0000);
        check("rc_an", 16'(an), 16'h000F);
        check("rc_seg", 16'(seg), 16'h007F);
        @(posedge clk);
        #1;
        rst = 1'b0;
        tick();
        check("rc_first_an", 16'(an), 16'h000E);
        check("rc_first_seg", 16'(seg), 16'(G0));
        check_digits("rc_clear", G0, G0, G0, G0);

        do_load(14'd25, 1'b1);
        tick();
        check("ign_busy", 16'(busy), 16'h0001);
        value = 14'h00F;
        mode  = 1'b0;
        load  = 1'b1;
        tick();
        load  = 1'b0;
        wait_idle("ign_idle");
        check_digits("ign", G5, G2, G0, G0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
